// File: rtl/als_sample_scheduler.sv
// Ambient-light sample scheduler: periodic SPI conversion requests, per-conversion timeout, block averaging.
// Define ALS_MINMAX_EN to build raw min/max sample tracking; otherwise min_out/max_out are constant.
module als_sample_scheduler #(
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int AVG_LOG2      = 3,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic       clk_10Mhz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear_err,
  output logic       spi_start,
  input  logic       spi_done,
  input  logic [7:0] spi_data,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  output logic       timeout_err,
  output logic       overrun,
  output logic [7:0] min_out,
  output logic [7:0] max_out
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] BLOCK_N  = CW'(1 << AVG_LOG2);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, START, WAIT_DONE, PUBLISH} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] period_cnt;
  logic          tick;
  logic [TW-1:0] tmo_cnt;
  logic [AW-1:0] acc;
  logic [CW-1:0] sample_cnt;
  logic          accept;
  logic          tmo_hit;

  function automatic logic [7:0] avg_trunc(input logic [AW-1:0] a);
    avg_trunc = 8'(a >> AVG_LOG2);
  endfunction

  // A conversion answered in the same cycle the timeout expires is still accepted.
  assign accept  = (state == WAIT_DONE) && spi_done;
  assign tmo_hit = (state == WAIT_DONE) && !spi_done && (tmo_cnt == TMO_LAST);

  // Period counter: tick is a registered flag for the cycle after the wrap to 0.
  always_ff @(posedge clk_10Mhz or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      tick       <= 1'b0;
    end else if (!enable) begin
      period_cnt <= '0;
      tick       <= 1'b0;
    end else if (period_cnt == PER_LAST) begin
      period_cnt <= '0;
      tick       <= 1'b1;
    end else begin
      period_cnt <= period_cnt + PW'(1);
      tick       <= 1'b0;
    end
  end

  always_ff @(posedge clk_10Mhz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (enable) state_nx = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)   state_nx = IDLE;
        else if (tick) state_nx = START;
      end
      START:     state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (accept) begin
          if (sample_cnt + CW'(1) == BLOCK_N) state_nx = PUBLISH;
          else                                state_nx = enable ? WAIT_TICK : IDLE;
        end else if (tmo_hit) begin
          state_nx = enable ? WAIT_TICK : IDLE;
        end
      end
      PUBLISH:   state_nx = enable ? WAIT_TICK : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_10Mhz or negedge reset_n) begin
    if (!reset_n) begin
      spi_start   <= 1'b0;
      avg_valid   <= 1'b0;
      avg_out     <= '0;
      tmo_cnt     <= '0;
      acc         <= '0;
      sample_cnt  <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      spi_start <= (state_nx == START);
      avg_valid <= (state == PUBLISH);
      tmo_cnt   <= (state == WAIT_DONE) ? tmo_cnt + TW'(1) : '0;
      if (state == PUBLISH) avg_out <= avg_trunc(acc);
      if (state == PUBLISH || state == IDLE) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else if (accept) begin
        acc        <= acc + AW'(spi_data);
        sample_cnt <= sample_cnt + CW'(1);
      end
      // Sticky flags: a set event beats a simultaneous clear.
      if (tmo_hit)        timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (tick && state != WAIT_TICK) overrun <= 1'b1;
      else if (clear_err)             overrun <= 1'b0;
    end
  end

`ifdef ALS_MINMAX_EN
  logic [7:0] min_base, max_base;

  always_comb begin
    min_base = clear_err ? 8'hFF : min_out;
    max_base = clear_err ? 8'h00 : max_out;
  end

  always_ff @(posedge clk_10Mhz or negedge reset_n) begin
    if (!reset_n) begin
      min_out <= 8'hFF;
      max_out <= 8'h00;
    end else if (accept) begin
      min_out <= (spi_data < min_base) ? spi_data : min_base;
      max_out <= (spi_data > max_base) ? spi_data : max_base;
    end else begin
      min_out <= min_base;
      max_out <= max_base;
    end
  end
`else
  assign min_out = 8'hFF;
  assign max_out = 8'h00;
`endif

endmodule

// File: doc/als_sample_scheduler.md
# als_sample_scheduler

Sequences the ambient-light SPI reader. It issues conversion requests on a fixed period, waits for each result with a timeout, and averages a power-of-two block of samples. It publishes the averaged byte with a one-cycle valid strobe. It sits between the light-sensor SPI engine and the display/consumer logic, and runs entirely in the 10 MHz domain.

## Interface
- SAMPLE_PERIOD, 1000000: cycles between conversion-start ticks (100 ms at 10 MHz); legal range is ≥ TIMEOUT_CYC+4.
- AVG_LOG2, 3: log2 of the samples averaged per result (8); range 0–4.
- TIMEOUT_CYC, 64: maximum cycles from spi_start to spi_done.
- clk_10Mhz  in  1  10 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = scheduling active.
- clear_err  in  1  one-cycle pulse; clears timeout_err and overrun.
- spi_start  out  1  one-cycle conversion request to the SPI engine.
- spi_done  in  1  one-cycle strobe from the SPI engine; spi_data is valid in the same cycle.
- spi_data  in  8  conversion result.
- avg_out  out  8  last published average; held between publishes.
- avg_valid  out  1  one-cycle strobe; avg_out is new in the same cycle.
- timeout_err  out  1  sticky flag: a conversion timed out.
- overrun  out  1  sticky flag: a tick arrived while a conversion was outstanding.
- min_out, max_out  out  8 each  raw extremes (see Configuration).

## Operation
- Period counter: runs 0..SAMPLE_PERIOD-1 and wraps while enable=1. It is held at 0 while enable=0. A tick occurs on wrap to 0.
- States:
  - IDLE: enable=1 → WAIT_TICK. The counter is released in the same cycle.
  - WAIT_TICK: on tick → START.
  - START: spi_start=1 for exactly this cycle → WAIT_DONE. The timeout counter is cleared.
  - WAIT_DONE: if spi_done=1, accumulate spi_data and increment sample_cnt.
    - If sample_cnt reaches 2^AVG_LOG2 → PUBLISH.
    - Otherwise → WAIT_TICK, or → IDLE if enable=0.
  - WAIT_DONE timeout: when the timeout counter reaches TIMEOUT_CYC without spi_done, set timeout_err and discard that sample only (accumulator and count unchanged) → WAIT_TICK, or → IDLE if enable=0.
  - PUBLISH: register avg_out = acc >> AVG_LOG2 (truncate), pulse avg_valid, clear acc and sample_cnt → WAIT_TICK, or → IDLE if enable=0.
- Accumulator width is 8+AVG_LOG2 bits, so it never overflows. With AVG_LOG2=0 the raw sample passes through.
- A tick in any state other than WAIT_TICK sets overrun and is dropped. It is never queued.
- enable falling: any outstanding conversion completes (done or timeout) first; no new spi_start is issued. On entry to IDLE, acc and sample_cnt clear and the partial block is discarded. avg_out is retained.
- spi_done outside WAIT_DONE is ignored. A late done that arrives after a timeout does not accumulate.
- Simultaneous events:
  - clear_err in the same cycle as a new set event: set wins.
  - spi_done in the same cycle the timeout is reached: done wins, with no error.

## Timing
- Reset values: spi_start=0, avg_out=0, avg_valid=0, timeout_err=0, overrun=0, min_out=8'hFF, max_out=8'h00. State is IDLE and all counters are 0.
- Tick to spi_start: 1 cycle, registered.
- spi_done of the final sample to avg_valid high: 2 cycles (edge 1 enters PUBLISH, edge 2 registers the output).
- Timeout: timeout_err rises TIMEOUT_CYC+1 cycles after the spi_start cycle.
- First spi_start after enable rises: SAMPLE_PERIOD+1 cycles.
- All outputs are registered; no combinational input-to-output paths.
- Reset assertion mid-operation forces reset values immediately (asynchronously). The first tick follows a full SAMPLE_PERIOD after reset release.

## Configuration
- ALS_MINMAX_EN defined: min_out and max_out track the minimum and maximum of every accepted raw sample since reset. Both update on the edge that accepts spi_done. clear_err also re-arms them to FF/00.
- ALS_MINMAX_EN undefined: no tracking logic is built, and min_out/max_out are held at constants 8'hFF/8'h00.

## Test plan
- Bench parameters: SAMPLE_PERIOD=100, AVG_LOG2=2, TIMEOUT_CYC=20, with an SPI model that answers 5 cycles after spi_start.
- Basic average: samples 10, 20, 30, 41 → single avg_valid pulse with avg_out=25, 2 cycles after the 4th done; spi_start pulses spaced exactly 100 cycles apart.
- Saturation: four samples of 255 → avg_out=255 with no wrap. Then four samples of 0 → avg_out=0.
- Timeout: model silent on the 2nd request → timeout_err=1 exactly 21 cycles after that spi_start. A done arriving 30 cycles late is ignored. Average publishes after 4 accepted samples. clear_err then clears the flag.
- Enable and reset: enable dropped 2 cycles after spi_start → that sample completes, state returns to IDLE, and there are no further spi_start pulses. Re-enable after 2 accepted samples → a full 4 new samples are needed before avg_valid. reset_n pulsed mid-WAIT_DONE → all outputs return to reset values immediately.
- Overrun: model delays done to 150 cycles with TIMEOUT_CYC=200 and SAMPLE_PERIOD=100 → overrun=1 and no extra spi_start is issued.
- MINMAX (ALS_MINMAX_EN): samples 40, 7, 200, 90 → min_out=7, max_out=200. Without the macro, the outputs read FF/00 throughout.
